// File: rtl/ip_param_buf_write_pkg.sv
// Shared definitions for the FC parameter ping-pong buffer write/read/control blocks.
package ip_param_buf_write_pkg;

  localparam int unsigned       BUF_AW = 9;
  localparam int unsigned       FW_DEF = 32;
  localparam logic [BUF_AW-1:0] WL_DEF = 9'd288;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_FILL     = 3'd2,
    ST_SYNC     = 3'd3,
    ST_LAST     = 3'd4
  } state_t;

endpackage

// File: rtl/ip_param_wr_addr_cnt.sv
// Loadable buffer address down-counter; reloads LOAD_VAL after reaching zero.
module ip_param_wr_addr_cnt
  import ip_param_buf_write_pkg::*;
#(
  parameter int unsigned    AW       = BUF_AW,
  parameter logic [AW-1:0]  LOAD_VAL = WL_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load_i,
  input  logic          dec_i,
  output logic [AW-1:0] cnt_o,
  output logic          zero_o
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= LOAD_VAL;
    end else if (load_i) begin
      r_cnt <= LOAD_VAL;
    end else if (dec_i) begin
      r_cnt <= (r_cnt == '0) ? LOAD_VAL : r_cnt - 1'b1;
    end
  end

  assign cnt_o  = r_cnt;
  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/ip_param_buf_write.sv
// Write stage of the FC parameter ping-pong buffer: bias then WL weights per neuron, top address down.
// Optional running-XOR checksum outputs enabled by IP_PARAM_WR_CHKSUM_EN.
module ip_param_buf_write
  import ip_param_buf_write_pkg::*;
#(
  parameter int unsigned        FW = FW_DEF,
  parameter logic [BUF_AW-1:0]  WL = WL_DEF,
  parameter int unsigned        CW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ip_start_i,
  input  logic          ip_done_i,
  input  logic [CW-1:0] num_neuron_i,
  input  logic [FW-1:0] ddr_data_i,
  input  logic          ddr_valid_i,
  output logic          ddr_ready_o,
  input  logic [1:0]    param_buf_full_i,
  input  logic          wr_buf_sel_i,
  output logic          buf0_we_o,
  output logic          buf1_we_o,
  output logic [8:0]    wr_addr_o,
  output logic [FW-1:0] wr_data_o,
  output logic          wr_buf_done_o,
  output logic          layer_wr_done_o,
  output logic          busy_o
`ifdef IP_PARAM_WR_CHKSUM_EN
  ,
  output logic [FW-1:0] chksum_o,
  output logic          chksum_valid_o
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_num;
  logic [CW-1:0]       r_fill_cnt;
  logic                r_sel;
  logic                r_we0;
  logic                r_we1;
  logic [BUF_AW-1:0]   r_addr;
  logic [FW-1:0]       r_data;
  logic                r_wr_done;
  logic                r_layer_done;

  logic                w_hs;
  logic                w_acc;
  logic                w_fill_start;
  logic                w_last_word;
  logic [BUF_AW-1:0]   w_addr;
  logic                w_addr_zero;

  assign ddr_ready_o  = (r_state == ST_FILL);
  assign w_hs         = ddr_ready_o & ddr_valid_i;
  // A word accepted in the abort cycle is dropped, never written.
  assign w_acc        = w_hs & ~ip_done_i;
  assign w_fill_start = (r_state == ST_WAIT_BUF) & ~param_buf_full_i[wr_buf_sel_i] & ~ip_done_i;
  assign w_last_word  = w_acc & w_addr_zero;

  ip_param_wr_addr_cnt #(
    .AW       (BUF_AW),
    .LOAD_VAL (WL)
  ) u_addr_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load_i (ip_done_i | w_fill_start),
    .dec_i  (w_acc),
    .cnt_o  (w_addr),
    .zero_o (w_addr_zero)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (ip_start_i) w_next = (num_neuron_i == '0) ? ST_LAST : ST_WAIT_BUF;
      ST_WAIT_BUF: if (!param_buf_full_i[wr_buf_sel_i]) w_next = ST_FILL;
      ST_FILL:     if (w_hs && w_addr_zero) w_next = ST_SYNC;
      ST_SYNC:     w_next = (r_fill_cnt == r_num) ? ST_LAST : ST_WAIT_BUF;
      ST_LAST:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (ip_done_i) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_num      <= '0;
      r_fill_cnt <= '0;
      r_sel      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && ip_start_i && !ip_done_i) r_num <= num_neuron_i;
      if (w_fill_start) r_sel <= wr_buf_sel_i;
      if (ip_done_i || (r_state == ST_LAST)) r_fill_cnt <= '0;
      else if (w_last_word)                  r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_we0        <= 1'b0;
      r_we1        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_wr_done    <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_we0        <= w_acc & ~r_sel;
      r_we1        <= w_acc &  r_sel;
      r_wr_done    <= w_last_word;
      r_layer_done <= (r_state == ST_LAST) & ~ip_done_i;
      if (w_acc) begin
        r_addr <= w_addr;
        r_data <= ddr_data_i;
      end
    end
  end

  assign buf0_we_o       = r_we0;
  assign buf1_we_o       = r_we1;
  assign wr_addr_o       = r_addr;
  assign wr_data_o       = r_data;
  assign wr_buf_done_o   = r_wr_done;
  assign layer_wr_done_o = r_layer_done;
  assign busy_o          = (r_state != ST_IDLE);

`ifdef IP_PARAM_WR_CHKSUM_EN
  logic [FW-1:0] r_chk;
  logic          r_chk_valid;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_chk       <= '0;
      r_chk_valid <= 1'b0;
    end else if (ip_done_i) begin
      r_chk       <= '0;
      r_chk_valid <= 1'b0;
    end else begin
      r_chk_valid <= w_last_word;
      if (w_fill_start) r_chk <= '0;
      else if (w_acc)   r_chk <= r_chk ^ ddr_data_i;
    end
  end

  assign chksum_o       = r_chk;
  assign chksum_valid_o = r_chk_valid;
`endif

endmodule

// File: tb/tb_ip_param_buf_write.sv
// Directed self-checking bench for ip_param_buf_write (checksum checks when IP_PARAM_WR_CHKSUM_EN is defined).
module tb_ip_param_buf_write;

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 16;
  localparam logic [8:0]  WL = 9'd288;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          ip_start_i;
  logic          ip_done_i;
  logic [CW-1:0] num_neuron_i;
  logic [FW-1:0] ddr_data_i;
  logic          ddr_valid_i;
  logic          ddr_ready_o;
  logic [1:0]    param_buf_full_i;
  logic          wr_buf_sel_i;
  logic          buf0_we_o;
  logic          buf1_we_o;
  logic [8:0]    wr_addr_o;
  logic [FW-1:0] wr_data_o;
  logic          wr_buf_done_o;
  logic          layer_wr_done_o;
  logic          busy_o;
`ifdef IP_PARAM_WR_CHKSUM_EN
  logic [FW-1:0] chksum_o;
  logic          chksum_valid_o;
`endif

  ip_param_buf_write #(
    .FW (FW),
    .WL (WL),
    .CW (CW)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .ip_start_i       (ip_start_i),
    .ip_done_i        (ip_done_i),
    .num_neuron_i     (num_neuron_i),
    .ddr_data_i       (ddr_data_i),
    .ddr_valid_i      (ddr_valid_i),
    .ddr_ready_o      (ddr_ready_o),
    .param_buf_full_i (param_buf_full_i),
    .wr_buf_sel_i     (wr_buf_sel_i),
    .buf0_we_o        (buf0_we_o),
    .buf1_we_o        (buf1_we_o),
    .wr_addr_o        (wr_addr_o),
    .wr_data_o        (wr_data_o),
    .wr_buf_done_o    (wr_buf_done_o),
    .layer_wr_done_o  (layer_wr_done_o),
    .busy_o           (busy_o)
`ifdef IP_PARAM_WR_CHKSUM_EN
    ,
    .chksum_o         (chksum_o),
    .chksum_valid_o   (chksum_valid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]  exp_addr;
  logic        exp_half;
  logic [31:0] idx;
  logic [31:0] exp_chk;
  logic [31:0] last_chk;
  logic        auto_sel;
  logic        valid_toggle;
  logic        data_is_addr;
  int          wr0, wr1, done_cnt, layer_cnt, ready_cyc;
  int          cyc_no, last_done_cyc, last_layer_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the write the DUT owes for this cycle's handshake and check it after the edge.
  task automatic cyc();
    logic        hs;
    logic [31:0] d;
    hs = ddr_ready_o & ddr_valid_i & ~ip_done_i;
    d  = ddr_data_i;
    @(posedge clk_i); #1;
    cyc_no++;
    chk("we_exclusive", buf0_we_o & buf1_we_o, 0);
    if (hs) begin
      chk("we_half", {buf1_we_o, buf0_we_o}, exp_half ? 2'b10 : 2'b01);
      chk("wr_addr", wr_addr_o, exp_addr);
      chk("wr_data", wr_data_o, d);
      chk("done_on_last", wr_buf_done_o, (exp_addr == 9'd0));
      exp_chk = exp_chk ^ d;
      if (exp_half) wr1++; else wr0++;
      exp_addr = (exp_addr == 9'd0) ? WL : exp_addr - 9'd1;
      idx++;
      ddr_data_i = data_is_addr ? 32'(exp_addr) : (32'hA500_0000 ^ idx);
    end else begin
      chk("no_we", {buf1_we_o, buf0_we_o}, 0);
      chk("no_done", wr_buf_done_o, 0);
    end
    if (ddr_ready_o) ready_cyc++;
    if (wr_buf_done_o) begin
      done_cnt++;
      last_done_cyc = cyc_no;
`ifdef IP_PARAM_WR_CHKSUM_EN
      chk("chksum_valid", chksum_valid_o, 1);
      chk("chksum", chksum_o, exp_chk);
      last_chk = chksum_o;
`endif
      exp_chk = '0;
      if (auto_sel) begin
        wr_buf_sel_i = ~wr_buf_sel_i;
        exp_half     = wr_buf_sel_i;
      end
    end
    if (layer_wr_done_o) begin
      layer_cnt++;
      last_layer_cyc = cyc_no;
    end
    if (valid_toggle) ddr_valid_i = ~ddr_valid_i;
  endtask

  task automatic start(input logic [CW-1:0] n);
    num_neuron_i = n;
    ip_start_i   = 1'b1;
    cyc();
    ip_start_i   = 1'b0;
  endtask

  task automatic run_layer(input int budget);
    int s;
    s = layer_cnt;
    for (int i = 0; i < budget && layer_cnt == s; i++) cyc();
    chk("layer_done_seen", layer_cnt - s, 1);
  endtask

  task automatic clr_counts();
    wr0 = 0; wr1 = 0; done_cnt = 0; ready_cyc = 0;
  endtask

  initial begin
    rstn_i = 1'b0; ip_start_i = 1'b0; ip_done_i = 1'b0; num_neuron_i = '0;
    ddr_valid_i = 1'b1; param_buf_full_i = 2'b00; wr_buf_sel_i = 1'b0;
    exp_addr = WL; exp_half = 1'b0; idx = '0; exp_chk = '0; last_chk = '0;
    ddr_data_i = 32'hA500_0000;
    auto_sel = 1'b1; valid_toggle = 1'b0; data_is_addr = 1'b0;
    layer_cnt = 0; cyc_no = 0; last_done_cyc = 0; last_layer_cyc = 0;
    clr_counts();

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_we0", buf0_we_o, 0);
    chk("rst_we1", buf1_we_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_done", wr_buf_done_o, 0);
    chk("rst_layer", layer_wr_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ddr_ready_o, 0);
    rstn_i = 1'b1;
    cyc(); cyc();
    chk("idle_busy", busy_o, 0);

    // Two fills, continuous valid, select toggling
    start(16'd2);
    chk("t1_busy", busy_o, 1);
    run_layer(1500);
    chk("t1_wr0", wr0, 289);
    chk("t1_wr1", wr1, 289);
    chk("t1_dones", done_cnt, 2);
    chk("t1_layer_lat", last_layer_cyc - last_done_cyc, 2);
    chk("t1_idle", busy_o, 0);

    // Both halves full after first fill: stall, then resume on half 1
    clr_counts();
    start(16'd2);
    for (int i = 0; i < 600 && done_cnt == 0; i++) cyc();
    chk("t2_first_done", done_cnt, 1);
    param_buf_full_i = 2'b11;
    ready_cyc = 0;
    repeat (20) cyc();
    chk("t2_stall_ready", ready_cyc, 0);
    chk("t2_stall_busy", busy_o, 1);
    chk("t2_stall_wr1", wr1, 0);
    param_buf_full_i = 2'b01;
    cyc(); cyc();
    chk("t2_resume", (ready_cyc != 0), 1);
    run_layer(600);
    chk("t2_wr0", wr0, 289);
    chk("t2_wr1", wr1, 289);
    param_buf_full_i = 2'b00;

    // Valid toggling mid-fill
    clr_counts();
    valid_toggle = 1'b1;
    start(16'd1);
    run_layer(1500);
    valid_toggle = 1'b0;
    ddr_valid_i  = 1'b1;
    chk("t3_wr0", wr0, 289);
    chk("t3_wr1", wr1, 0);
    chk("t3_dones", done_cnt, 1);

    // Abort at address 100, then restart from the top address
    clr_counts();
    start(16'd1);
    for (int i = 0; i < 400 && exp_addr != 9'd100; i++) cyc();
    chk("t4_reach100", exp_addr, 100);
    ip_done_i = 1'b1;
    cyc();
    ip_done_i = 1'b0;
    chk("t4_busy", busy_o, 0);
    chk("t4_ready", ddr_ready_o, 0);
    repeat (5) cyc();
    chk("t4_no_done", done_cnt, 0);
    exp_addr = WL;
    exp_chk  = '0;
    clr_counts();
    start(16'd1);
    run_layer(700);
    chk("t4_restart_wr", wr0 + wr1, 289);
    chk("t4_restart_done", done_cnt, 1);

    // Zero neurons
    clr_counts();
    start(16'd0);
    chk("t5_busy", busy_o, 1);
    chk("t5_layer_early", layer_wr_done_o, 0);
    cyc();
    chk("t5_layer", layer_wr_done_o, 1);
    cyc();
    chk("t5_layer_pulse", layer_wr_done_o, 0);
    chk("t5_writes", wr0 + wr1, 0);
    chk("t5_dones", done_cnt, 0);

    // ip_done beats ip_start
    ip_done_i = 1'b1;
    start(16'd1);
    ip_done_i = 1'b0;
    chk("t6_busy", busy_o, 0);
    cyc();
    chk("t6_busy_hold", busy_o, 0);

`ifdef IP_PARAM_WR_CHKSUM_EN
    // Data equal to address: XOR of 0..288 is 288
    clr_counts();
    data_is_addr = 1'b1;
    exp_addr     = WL;
    ddr_data_i   = 32'(WL);
    start(16'd1);
    run_layer(700);
    chk("chk_value", last_chk, 32'd288);
    chk("chk_hold", chksum_o, 32'd288);
    data_is_addr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ip_param_buf_write.md
Name: ip_param_buf_write

Overview:
Upstream write stage of the FC parameter ping-pong buffer. Takes the DDR parameter stream and fills one half of the buffer per neuron: one bias word, then WL weight words. Writes run from the highest address down, with the bias at address WL and the last weight at address 0. Uses the buffer controller's full/select status for flow control, and pulses wr_buf_done_o once per completed fill.

Parameters:
FW, 32, parameter word width
WL, 9'd288, top buffer address; one fill is WL+1 words (1 bias + WL weights)
CW, 16, width of neuron counter

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
ip_start_i  in  1  one-cycle pulse, start of layer parameter load
ip_done_i  in  1  layer done/abort, synchronous clear
num_neuron_i  in  CW  fills (neurons) in this layer, sampled on ip_start_i
ddr_data_i  in  FW  parameter word from DDR reader
ddr_valid_i  in  1  ddr_data_i valid
ddr_ready_o  out  1  word accepted when valid&ready
param_buf_full_i  in  2  per-half full flags from buffer controller
wr_buf_sel_i  in  1  half the controller expects next
buf0_we_o  out  1  write enable, half 0
buf1_we_o  out  1  write enable, half 1
wr_addr_o  out  9  write address
wr_data_o  out  FW  write data
wr_buf_done_o  out  1  one-cycle pulse, fill complete
layer_wr_done_o  out  1  one-cycle pulse, all num_neuron_i fills written
busy_o  out  1  high while not IDLE

Behaviour:
- Reset: all outputs 0; internal address = WL; fill count = 0; state IDLE.
- States: IDLE, WAIT_BUF, FILL, SYNC, LAST.
- IDLE:
  - On ip_start_i, latch num_neuron_i.
  - If num_neuron_i==0 -> LAST.
  - Otherwise -> WAIT_BUF.
  - ip_start_i in any other state is ignored.
- WAIT_BUF:
  - If param_buf_full_i[wr_buf_sel_i]==0 -> FILL; latch wr_buf_sel_i as the target half and set address = WL.
  - Otherwise stay.
- FILL:
  - ddr_ready_o=1 (combinational, state==FILL); it is 0 in every other state.
  - Per handshake: the next cycle drives buf<sel>_we_o=1, wr_addr_o=current address, wr_data_o=ddr_data_i. Write latency is 1 cycle, and outputs are registered. Then address decrements.
  - No handshake: we=0; wr_addr_o and wr_data_o hold their values.
  - Handshake at address 0 (word WL+1): fill count increments and state -> SYNC. wr_buf_done_o=1 in the same cycle as that final we.
- SYNC: one cycle, so the controller's full/select update is visible. Then:
  - If fill count==latched num_neuron_i -> LAST.
  - Otherwise -> WAIT_BUF.
- LAST: layer_wr_done_o=1 for one cycle; fill count cleared; -> IDLE.
- Address wrap: after address 0 the counter reloads to WL. It never underflows.
- Neither half free: stall in WAIT_BUF indefinitely. No DDR words are accepted.
- ip_done_i (any state, highest priority after reset):
  - Next cycle: state IDLE, address WL, count 0.
  - we/done/layer_done outputs 0; an in-flight accepted word is discarded (no write).
  - ip_done_i together with ip_start_i: ip_done_i wins.
- ddr_valid_i dropping mid-fill: the address holds and the fill resumes on the next valid. No timeout.
- buf0_we_o and buf1_we_o are never high together.

Optional Feature:
IP_PARAM_WR_CHKSUM_EN:
- Defined: adds outputs chksum_o[FW] and chksum_valid_o.
  - chksum_o is a running XOR of every word accepted in the current fill, cleared at FILL entry.
  - chksum_valid_o pulses with wr_buf_done_o, and chksum_o holds until the next FILL entry.
  - ip_done_i clears both.
- Undefined: ports absent, no checksum logic.

Decomposition:
- common.v holds the shared definitions:
  - state encodings (3-bit localparams)
  - buffer address width (9)
  - default FW/WL values, also used by ip_param_buf_control
- One sub-module: ip_param_wr_addr_cnt. It is a loadable down-counter (load WL, dec enable, zero flag) and is also reusable on the read side.

Test Plan:
- Reset then ip_start_i with num_neuron_i=2, WL=288, ddr_valid_i always 1, full=00, sel toggling:
  - half 0 gets 289 writes, addresses 288..0, then half 1 gets 289 writes.
  - 2 wr_buf_done_o pulses; layer_wr_done_o 2 cycles after the second done pulse.
- param_buf_full_i=11 after the first fill: ddr_ready_o stays 0 and no we pulses. Clear full[1] -> FILL resumes within 2 cycles, targeting half 1.
- ddr_valid_i toggling 1010… during FILL: exactly one write per valid cycle, addresses strictly decreasing, data matches the input order.
- ip_done_i asserted at address 100 mid-fill: next cycle busy_o=0 and no further we. A new ip_start_i restarts at address 288.
- num_neuron_i=0: layer_wr_done_o one cycle after IDLE exits, with no writes and no wr_buf_done_o.
- With IP_PARAM_WR_CHKSUM_EN, data = address index: chksum_o equals the XOR of 0..288 on the done pulse.
